// File: rtl/breakout_game_ctrl.sv
//-----------------------------------------------------------------------------
// breakout_game_ctrl
//
// Game-flow controller for a Breakout-style video game. It sequences the game
// through attract (IDLE), serve (NEWBALL), play (PLAY) and game-over (OVER)
// screens. It also keeps lives and a 3-digit BCD score, and pulses the
// ball/brick reload strobes that the playfield logic consumes.
//
// Parameters
//   LIVES_INIT      lives loaded at game start (1..3)
//   NEWBALL_FRAMES  frames spent on the serve screen before play resumes
//   OVER_FRAMES     frames the game-over text stays up
//
// Ports
//   clk            system/pixel clock
//   reset_n        asynchronous active-low reset
//   btn[1:0]       raw push-buttons, active-high, asynchronous to clk
//   refr_tick      one-cycle pulse per video frame
//   ball_miss      one-cycle pulse: ball left the bottom edge
//   brick_hit      one-cycle pulse: one brick destroyed
//   bricks_clear   level: no bricks remain
//   game_run       enables ball/paddle motion
//   ball_reload    one-cycle pulse: re-centre the ball
//   bricks_reload  one-cycle pulse: restore the brick wall
//   lives[1:0]     remaining lives
//   score[11:0]    3-digit BCD score
//   hiscore[11:0]  3-digit BCD high score
//   text_sel[1:0]  overlay text: 0 none, 1 start, 2 ready, 3 game over
//
// Build option
//   BREAKOUT_HISCORE_EN  when defined, a high-score register is kept across
//                        games. Otherwise hiscore reads 12'h000.
//-----------------------------------------------------------------------------
module breakout_game_ctrl #(
   parameter int unsigned LIVES_INIT     = 3,
   parameter int unsigned NEWBALL_FRAMES = 120,
   parameter int unsigned OVER_FRAMES    = 180
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  btn,
   input  logic        refr_tick,
   input  logic        ball_miss,
   input  logic        brick_hit,
   input  logic        bricks_clear,
   output logic        game_run,
   output logic        ball_reload,
   output logic        bricks_reload,
   output logic [1:0]  lives,
   output logic [11:0] score,
   output logic [11:0] hiscore,
   output logic [1:0]  text_sel
);

   localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);
   localparam logic [7:0] NB_LIMIT   = 8'(NEWBALL_FRAMES);
   localparam logic [7:0] OV_LIMIT   = 8'(OVER_FRAMES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      NEWBALL = 2'd1,
      PLAY    = 2'd2,
      OVER    = 2'd3
   } state_t;

   state_t      state;
   logic [7:0]  timer;
   logic        sync_q1;
   logic        sync_q2;
   logic        press_q;
   logic        press;
   logic        go_over;
   logic [11:0] score_nxt;

   // Add one to a 3-digit BCD value, holding at 999 rather than wrapping.
   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [3:0] d0;
      logic [3:0] d1;
      logic [3:0] d2;
      d2 = v[11:8];
      d1 = v[7:4];
      d0 = v[3:0];
      if (v != 12'h999) begin
         if (d0 != 4'd9) begin
            d0 = d0 + 4'd1;
         end else begin
            d0 = 4'd0;
            if (d1 != 4'd9) begin
               d1 = d1 + 4'd1;
            end else begin
               d1 = 4'd0;
               d2 = d2 + 4'd1;
            end
         end
      end
      return {d2, d1, d0};
   endfunction

   // Both buttons act as one "press". The OR is taken before the two-flop
   // synchroniser, and a third flop provides the rising-edge reference.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q1 <= |btn;
         sync_q2 <= sync_q1;
         press_q <= sync_q2;
      end
   end

   assign press = sync_q2 & ~press_q;

   // A brick hit is still scored in the same cycle as a miss or a cleared wall.
   // score_nxt is therefore the value the score takes when play leaves PLAY.
   assign score_nxt = (state == PLAY && brick_hit) ? bcd_inc(score) : score;
   assign go_over   = (state == PLAY) && ball_miss && (lives == 2'd1);

   // Main game sequencer. Every output is a register that is updated together
   // with the state. The reload strobes default low each cycle, so each one
   // can only be high for the single cycle after a transition.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         timer         <= 8'd0;
         game_run      <= 1'b0;
         ball_reload   <= 1'b0;
         bricks_reload <= 1'b0;
         lives         <= 2'd0;
         score         <= 12'h000;
         text_sel      <= 2'd1;
      end else begin
         ball_reload   <= 1'b0;
         bricks_reload <= 1'b0;
         if (refr_tick) begin
            timer <= timer + 8'd1;
         end
         case (state)
            IDLE: begin
               if (press) begin
                  state         <= NEWBALL;
                  timer         <= 8'd0;
                  lives         <= LIVES_LOAD;
                  score         <= 12'h000;
                  ball_reload   <= 1'b1;
                  bricks_reload <= 1'b1;
                  game_run      <= 1'b0;
                  text_sel      <= 2'd2;
               end
            end
            NEWBALL: begin
               if (timer == NB_LIMIT || press) begin
                  state    <= PLAY;
                  timer    <= 8'd0;
                  game_run <= 1'b1;
                  text_sel <= 2'd0;
               end
            end
            PLAY: begin
               score <= score_nxt;
               if (go_over) begin
                  state    <= OVER;
                  timer    <= 8'd0;
                  lives    <= 2'd0;
                  game_run <= 1'b0;
                  text_sel <= 2'd3;
               end else if (ball_miss) begin
                  state       <= NEWBALL;
                  timer       <= 8'd0;
                  lives       <= lives - 2'd1;
                  ball_reload <= 1'b1;
                  game_run    <= 1'b0;
                  text_sel    <= 2'd2;
               end else if (bricks_clear) begin
                  state         <= NEWBALL;
                  timer         <= 8'd0;
                  ball_reload   <= 1'b1;
                  bricks_reload <= 1'b1;
                  game_run      <= 1'b0;
                  text_sel      <= 2'd2;
               end
            end
            OVER: begin
               if (timer == OV_LIMIT) begin
                  state    <= IDLE;
                  timer    <= 8'd0;
                  game_run <= 1'b0;
                  text_sel <= 2'd1;
               end
            end
            default: begin
               state    <= IDLE;
               timer    <= 8'd0;
               game_run <= 1'b0;
               text_sel <= 2'd1;
            end
         endcase
      end
   end

`ifdef BREAKOUT_HISCORE_EN
   logic [11:0] hiscore_q;

   // The final score is captured as the game ends. BCD ordering matches
   // numeric ordering, so a plain magnitude compare is enough.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hiscore_q <= 12'h000;
      end else if (go_over && (score_nxt > hiscore_q)) begin
         hiscore_q <= score_nxt;
      end
   end

   assign hiscore = hiscore_q;
`else
   assign hiscore = 12'h000;
`endif

endmodule

// File: tb/tb_breakout_game_ctrl.sv
//-----------------------------------------------------------------------------
// tb_breakout_game_ctrl
//
// Scoreboard bench for breakout_game_ctrl. Stimulus tasks update an abstract
// game model (integer lives/score/hiscore). They queue the output snapshot
// that each visible output change should produce. A negedge monitor pops one
// expected snapshot every time the DUT outputs change and compares the two.
//-----------------------------------------------------------------------------
module tb_breakout_game_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [1:0]  btn = 2'b00;
   logic        refr_tick = 1'b0;
   logic        ball_miss = 1'b0;
   logic        brick_hit = 1'b0;
   logic        bricks_clear = 1'b0;
   logic        game_run;
   logic        ball_reload;
   logic        bricks_reload;
   logic [1:0]  lives;
   logic [11:0] score;
   logic [11:0] hiscore;
   logic [1:0]  text_sel;

   int checks = 0;
   int fails = 0;
   string phase = "reset";

   logic [30:0] exp_q[$];
   logic [30:0] prev_snap;
   logic [30:0] dut_snap;

   // Abstract game model
   int m_lives = 0;
   int m_score = 0;
   int m_hi = 0;

   breakout_game_ctrl dut (
      .clk(clk),
      .reset_n(reset_n),
      .btn(btn),
      .refr_tick(refr_tick),
      .ball_miss(ball_miss),
      .brick_hit(brick_hit),
      .bricks_clear(bricks_clear),
      .game_run(game_run),
      .ball_reload(ball_reload),
      .bricks_reload(bricks_reload),
      .lives(lives),
      .score(score),
      .hiscore(hiscore),
      .text_sel(text_sel)
   );

   always #5 clk = ~clk;

   assign dut_snap = {game_run, ball_reload, bricks_reload, lives, score, hiscore, text_sel};

   function automatic logic [11:0] to_bcd(input int n);
      return 12'((n / 100) * 256 + ((n / 10) % 10) * 16 + (n % 10));
   endfunction

   function automatic logic [30:0] mk(input logic gr, input logic br, input logic kr,
                                      input int lv, input int sc, input int hi, input int ts);
      return {gr, br, kr, 2'(lv), to_bcd(sc), to_bcd(hi), 2'(ts)};
   endfunction

   // Compare one DUT output presentation against the next scoreboard entry.
   task automatic checkOutput(input logic [30:0] got);
      logic [30:0] want;
      checks++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("[TB] FAIL unexpected_change (%s): got %h, required no change from %h",
                  phase, got, prev_snap);
      end else begin
         want = exp_q.pop_front();
         if (got !== want) begin
            fails++;
            $display("[TB] FAIL output_change (%s): got %h, required %h", phase, got, want);
         end
      end
   endtask

   // Monitor: every change of the observable outputs is one DUT presentation.
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_snap = dut_snap;
      end else if (dut_snap !== prev_snap) begin
         checkOutput(dut_snap);
         prev_snap = dut_snap;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait, bounded, for the scoreboard to empty.
   task automatic wait_drain(input int budget, input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("[TB] FAIL %s: got %0d outputs still pending, required 0 within %0d cycles",
                  name, exp_q.size(), budget);
         exp_q.delete();
      end
   endtask

   task automatic check_reset(input string name);
      checks++;
      if (dut_snap !== mk(1'b0, 1'b0, 1'b0, 0, 0, 0, 1)) begin
         fails++;
         $display("[TB] FAIL %s: got %h, required %h", name, dut_snap,
                  mk(1'b0, 1'b0, 1'b0, 0, 0, 0, 1));
      end
   endtask

   // One-cycle pulse on the play inputs, then one idle cycle.
   task automatic applyStimulus(input logic h, input logic m, input logic c);
      brick_hit = h;
      ball_miss = m;
      bricks_clear = c;
      step();
      brick_hit = 1'b0;
      ball_miss = 1'b0;
      bricks_clear = 1'b0;
      step();
   endtask

   task automatic tick();
      refr_tick = 1'b1;
      step();
      refr_tick = 1'b0;
      repeat ($urandom_range(0, 2)) step();
   endtask

   task automatic do_press(input logic [1:0] b, input int hold, input logic expect_change);
      btn = b;
      if (expect_change) wait_drain(5, "press_latency");
      repeat (hold) step();
      btn = 2'b00;
      repeat (4) step();
   endtask

   task automatic start_game();
      phase = "start";
      m_lives = 3;
      m_score = 0;
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, m_lives, 0, m_hi, 2));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, m_lives, 0, m_hi, 2));
      do_press(2'b01, 6, 1'b1);
   endtask

   task automatic serve_press();
      phase = "serve_press";
      repeat (5) tick();
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, m_lives, m_score, m_hi, 0));
      do_press(2'b10, 2, 1'b1);
   endtask

   task automatic serve_timeout();
      phase = "serve_timeout";
      repeat (119) tick();
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, m_lives, m_score, m_hi, 0));
      tick();
      wait_drain(4, "serve_timeout");
   endtask

   task automatic hit();
      phase = "brick_hit";
      if (m_score < 999) begin
         m_score++;
         exp_q.push_back(mk(1'b1, 1'b0, 1'b0, m_lives, m_score, m_hi, 0));
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      wait_drain(2, "brick_hit");
   endtask

   task automatic miss(input logic h, input logic c);
      phase = "ball_miss";
      if (h && m_score < 999) m_score++;
      if (m_lives == 1) begin
         m_lives = 0;
`ifdef BREAKOUT_HISCORE_EN
         if (m_score > m_hi) m_hi = m_score;
`endif
         exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0, m_score, m_hi, 3));
      end else begin
         m_lives--;
         exp_q.push_back(mk(1'b0, 1'b1, 1'b0, m_lives, m_score, m_hi, 2));
         exp_q.push_back(mk(1'b0, 1'b0, 1'b0, m_lives, m_score, m_hi, 2));
      end
      applyStimulus(h, 1'b1, c);
      wait_drain(4, "ball_miss");
   endtask

   task automatic clear_wall();
      phase = "bricks_clear";
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, m_lives, m_score, m_hi, 2));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, m_lives, m_score, m_hi, 2));
      applyStimulus(1'b0, 1'b0, 1'b1);
      wait_drain(4, "bricks_clear");
   endtask

   task automatic finish_over();
      phase = "over_press_ignored";
      do_press(2'b01, 3, 1'b0);
      phase = "over_timeout";
      repeat (179) tick();
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0, m_score, m_hi, 1));
      tick();
      wait_drain(4, "over_timeout");
   endtask

   task automatic lose_all_lives();
      while (m_lives > 1) begin
         miss(1'b0, 1'b0);
         serve_press();
      end
      miss(1'b0, 1'b0);
   endtask

   initial begin
      #2 reset_n = 1'b0;
      repeat (3) step();
      check_reset("reset_state");
      reset_n = 1'b1;
      repeat (2) step();

      // Play inputs are ignored in IDLE
      phase = "idle_ignore";
      applyStimulus(1'b1, 1'b1, 1'b1);

      // Game 1: timeout serve, scoring, wall clear, combined miss, game over at 042
      start_game();
      phase = "newball_ignore";
      applyStimulus(1'b1, 1'b1, 1'b1);
      serve_timeout();
      repeat (10) hit();
      clear_wall();
      serve_press();
      miss(1'b0, 1'b0);
      serve_press();
      miss(1'b1, 1'b1);
      serve_press();
      repeat (31) hit();
      miss(1'b0, 1'b0);
      finish_over();

      // Game 2: ends at 017, hiscore must not drop
      start_game();
      serve_press();
      repeat (17) hit();
      lose_all_lives();
      finish_over();

      // Game 3: score saturation
      start_game();
      serve_press();
      repeat (1000) hit();
      repeat ($urandom_range(3, 12)) hit();
      lose_all_lives();
      finish_over();

      // Game 4: reset mid-game abandons it with no reload pulse
      start_game();
      serve_press();
      repeat ($urandom_range(2, 6)) hit();
      phase = "midgame_reset";
      reset_n = 1'b0;
      step();
      check_reset("midgame_reset");
      m_lives = 0;
      m_score = 0;
      m_hi = 0;
      reset_n = 1'b1;
      repeat (8) step();
      check_reset("after_reset_idle");

      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("[TB] FAIL final_queue: got %0d pending, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/breakout_game_ctrl.md
BREAKOUT_GAME_CTRL -- requirements
Module: breakout_game_ctrl

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3, meaning lives loaded at game start (legal 1..3).
REQ-002 SHALL have parameter NEWBALL_FRAMES, default 120, meaning serve delay in frames (8-bit).
REQ-003 SHALL have parameter OVER_FRAMES, default 180, meaning game-over display time in frames (8-bit).
REQ-004 SHALL have port clk  input  1  system/pixel clock; the block has one clock.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port btn  input  2  raw push-buttons, active-high, asynchronous to clk.
REQ-007 SHALL have port refr_tick  input  1  one-cycle pulse once per video frame.
REQ-008 SHALL have port ball_miss  input  1  one-cycle pulse: ball left the bottom edge.
REQ-009 SHALL have port brick_hit  input  1  one-cycle pulse: one brick destroyed.
REQ-010 SHALL have port bricks_clear  input  1  level: no bricks remain.
REQ-011 SHALL have port game_run  output  1  enables ball/paddle motion.
REQ-012 SHALL have port ball_reload  output  1  one-cycle pulse: re-centre the ball.
REQ-013 SHALL have port bricks_reload  output  1  one-cycle pulse: restore the brick wall.
REQ-014 SHALL have port lives  output  2  remaining lives.
REQ-015 SHALL have port score  output  12  3-digit BCD score.
REQ-016 SHALL have port hiscore  output  12  3-digit BCD high score.
REQ-017 SHALL have port text_sel  output  2  overlay text: 0 none, 1 start, 2 ready, 3 game over.

Function
REQ-018 SHALL derive press from the OR of btn through a 2-flop synchroniser and a rising-edge detector; a btn rise SHALL change state within 4 clk edges.
REQ-019 SHALL implement FSM states IDLE, NEWBALL, PLAY, OVER; all outputs are registered.
REQ-020 SHALL in IDLE hold game_run=0 and text_sel=1; on press go to NEWBALL, load lives=LIVES_INIT, clear score, and pulse ball_reload and bricks_reload for one cycle each.
REQ-021 SHALL clear an 8-bit frame timer on every state entry and increment it on refr_tick only.
REQ-022 SHALL in NEWBALL hold game_run=0 and text_sel=2; go to PLAY when timer==NEWBALL_FRAMES or on press, whichever comes first.
REQ-023 SHALL in PLAY hold game_run=1 and text_sel=0; brick_hit SHALL add 1 to score in BCD with digit carry, saturating at 999.
REQ-024 SHALL in PLAY on ball_miss: when lives==1, set lives=0 and go to OVER; otherwise decrement lives, pulse ball_reload, and go to NEWBALL.
REQ-025 SHALL in PLAY with bricks_clear=1 and no ball_miss pulse ball_reload and bricks_reload, go to NEWBALL, and leave lives unchanged.
REQ-026 SHALL give ball_miss priority over bricks_clear; a brick_hit in the same cycle SHALL still be scored.
REQ-027 SHALL ignore brick_hit, ball_miss and bricks_clear outside PLAY.
REQ-028 SHALL in OVER hold game_run=0 and text_sel=3, ignore press, hold score, and go to IDLE when timer==OVER_FRAMES.
REQ-029 SHALL never assert ball_reload or bricks_reload for more than one cycle per transition.

Reset
REQ-030 SHALL on reset_n low, asynchronously: state=IDLE, timer=0, game_run=0, ball_reload=0, bricks_reload=0, lives=0, score=0, hiscore=0, text_sel=1, synchroniser flops=0.
REQ-031 SHALL, when reset is applied mid-game, abandon the game immediately; the first cycle after release is IDLE and no reload pulse occurs.

Configuration
REQ-032 SHALL with BREAKOUT_HISCORE_EN defined load hiscore with score on entry to OVER if score>hiscore; hiscore is retained across games and cleared only by reset.
REQ-033 SHALL without BREAKOUT_HISCORE_EN tie hiscore to 12'h000 and include no hiscore register or comparator.

Verification
REQ-034 SHALL cover: reset, then btn=01 held 10 cycles -> NEWBALL within 4 edges, lives=3, score=000, single ball_reload and bricks_reload pulses.
REQ-035 SHALL cover: in NEWBALL, 120 refr_ticks with no press -> PLAY, game_run=1; with press after 5 ticks -> PLAY immediately.
REQ-036 SHALL cover: in PLAY, 1000 brick_hit pulses -> score 999 (12'h999), no wrap; 10 pulses from 0 -> 12'h010.
REQ-037 SHALL cover: 3 ball_miss pulses, each in PLAY -> lives 2,1,0, then OVER with text_sel=3; press ignored; IDLE after 180 ticks.
REQ-038 SHALL cover: ball_miss, brick_hit and bricks_clear together at lives=2 -> lives=1, score+1, NEWBALL, no bricks_reload.
REQ-039 SHALL cover: with BREAKOUT_HISCORE_EN, game 1 ends at score 042 and game 2 at 017 -> hiscore=12'h042; reset -> 12'h000.
